// File: rtl/deparser_pkg.sv
// deparser_pkg: shared widths, lookup-entry types and FSM states for the deparser merge/shift stage
package deparser_pkg;
    localparam int DEF_FIELD_WIDTH    = 16;
    localparam int DEF_HEAD_FIELD_NUM = 16;
    localparam int KEY_FILED_NUM      = 8;
    localparam int META_CANDI_NUM     = 8;
    localparam int KEY_OFFSET_WIDTH   = 5;
    localparam int REP_OFFSET_WIDTH   = 3;
    localparam int HEAD_SHIFT_WIDTH   = 5;
    localparam int META_SHIFT_WIDTH   = 4;
    typedef logic [KEY_OFFSET_WIDTH:0] key_off_t;
    typedef logic [REP_OFFSET_WIDTH:0] rep_off_t;
    typedef logic [DEF_FIELD_WIDTH-1:0] field_t;
    typedef enum logic {S_HEAD, S_BODY} state_t;
endpackage

// File: rtl/deparser_merge_shift_field_shifter.sv
// field_shifter: combinational left shift by whole fields with zero fill
module field_shifter
    import deparser_pkg::*;
#(
    parameter int NUM = DEF_HEAD_FIELD_NUM,
    parameter int W   = DEF_FIELD_WIDTH,
    parameter int SW  = HEAD_SHIFT_WIDTH
) (
    input  logic [NUM*W-1:0] i_data,
    input  logic [SW-1:0]    i_shift,
    output logic [NUM*W-1:0] o_data
);
    // output field i takes input field i+shift, or zero once that runs past the top
    always_comb begin
        o_data = '0;
        for (int i = 0; i < NUM; i++)
            if (i + int'(i_shift) < NUM) o_data[i*W +: W] = i_data[(i + int'(i_shift))*W +: W];
    end
endmodule

// File: rtl/deparser_merge_shift.sv
// deparser_merge_shift: header-beat metadata replace (S1) then header/meta field shift (S2)
module deparser_merge_shift
    import deparser_pkg::*;
#(
    parameter int FIELD_WIDTH    = DEF_FIELD_WIDTH,
    parameter int HEAD_FIELD_NUM = DEF_HEAD_FIELD_NUM,
    parameter int CNT_WIDTH      = 32,
    localparam int DATA_WIDTH    = HEAD_FIELD_NUM*FIELD_WIDTH,
    localparam int META_WIDTH    = META_CANDI_NUM*FIELD_WIDTH
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    input  logic [DATA_WIDTH-1:0]       i_data,
    input  logic [META_WIDTH-1:0]       i_meta,
    input  logic                        i_last,
    output logic                        o_ready,
    input  logic [KEY_OFFSET_WIDTH:0]   i_result [KEY_FILED_NUM],
    input  logic [REP_OFFSET_WIDTH:0]   i_replaceOffset [META_CANDI_NUM],
    input  logic [HEAD_SHIFT_WIDTH-1:0] i_headShift,
    input  logic [META_SHIFT_WIDTH-1:0] i_metaShift,
    output logic                        o_valid,
    output logic [DATA_WIDTH-1:0]       o_data,
    output logic [META_WIDTH-1:0]       o_meta,
    output logic                        o_last,
    input  logic                        i_ready,
    output logic [CNT_WIDTH-1:0]        o_pkt_cnt
);
    state_t                      state_q, state_d;
    logic                        s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic [DATA_WIDTH-1:0]       s1_data_q, s1_data_d;
    logic [META_WIDTH-1:0]       s1_meta_q, s1_meta_d;
    logic [HEAD_SHIFT_WIDTH-1:0] s1_hshift_q, s1_hshift_d;
    logic [META_SHIFT_WIDTH-1:0] s1_mshift_q, s1_mshift_d;
    logic                        s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic [DATA_WIDTH-1:0]       s2_data_q, s2_data_d;
    logic [META_WIDTH-1:0]       s2_meta_q, s2_meta_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic                        adv, head;
    logic [DATA_WIDTH-1:0]       rep_data, sh_data;
    logic [META_WIDTH-1:0]       sh_meta;
    logic [KEY_OFFSET_WIDTH:0]   hit_key [META_CANDI_NUM];

    for (genvar j = 0; j < META_CANDI_NUM; j++) begin : g_key
        assign hit_key[j] = i_result[i_replaceOffset[j][REP_OFFSET_WIDTH-1:0]];
    end

    // overlay candidates in ascending order so the highest candidate wins a shared field
    always_comb begin
        rep_data = i_data;
        for (int j = 0; j < META_CANDI_NUM; j++)
            if (i_replaceOffset[j][REP_OFFSET_WIDTH] && hit_key[j][KEY_OFFSET_WIDTH] &&
                int'(hit_key[j][KEY_OFFSET_WIDTH-1:0]) < HEAD_FIELD_NUM)
                rep_data[int'(hit_key[j][KEY_OFFSET_WIDTH-1:0])*FIELD_WIDTH +: FIELD_WIDTH] =
                    i_meta[j*FIELD_WIDTH +: FIELD_WIDTH];
    end

    field_shifter #(.NUM(HEAD_FIELD_NUM), .W(FIELD_WIDTH), .SW(HEAD_SHIFT_WIDTH)) u_head_shift (
        .i_data(s1_data_q), .i_shift(s1_hshift_q), .o_data(sh_data)
    );

    field_shifter #(.NUM(META_CANDI_NUM), .W(FIELD_WIDTH), .SW(META_SHIFT_WIDTH)) u_meta_shift (
        .i_data(s1_meta_q), .i_shift(s1_mshift_q), .o_data(sh_meta)
    );

    // pipeline advance, header/body FSM; body beats carry zero meta and zero shifts
    always_comb begin
        adv         = !s2_valid_q || i_ready;
        head        = state_q == S_HEAD;
        state_d     = (i_valid && adv) ? (i_last ? S_HEAD : S_BODY) : state_q;
        s1_valid_d  = adv ? i_valid : s1_valid_q;
        s1_last_d   = adv ? i_last : s1_last_q;
        s1_data_d   = adv ? (head ? rep_data : i_data) : s1_data_q;
        s1_meta_d   = adv ? (head ? i_meta : '0) : s1_meta_q;
        s1_hshift_d = adv ? (head ? i_headShift : '0) : s1_hshift_q;
        s1_mshift_d = adv ? (head ? i_metaShift : '0) : s1_mshift_q;
        s2_valid_d  = adv ? s1_valid_q : s2_valid_q;
        s2_last_d   = adv ? s1_last_q : s2_last_q;
        s2_data_d   = adv ? sh_data : s2_data_q;
        s2_meta_d   = adv ? sh_meta : s2_meta_q;
        cnt_d       = (s2_valid_q && i_ready && s2_last_q) ? cnt_q + 1'b1 : cnt_q;
    end

    // state registers with synchronous reset clearing everything
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_HEAD;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_data_q   <= '0;
            s1_meta_q   <= '0;
            s1_hshift_q <= '0;
            s1_mshift_q <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_data_q   <= '0;
            s2_meta_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_data_q   <= s1_data_d;
            s1_meta_q   <= s1_meta_d;
            s1_hshift_q <= s1_hshift_d;
            s1_mshift_q <= s1_mshift_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_data_q   <= s2_data_d;
            s2_meta_q   <= s2_meta_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_ready   = adv;
    assign o_valid   = s2_valid_q;
    assign o_data    = s2_data_q;
    assign o_meta    = s2_meta_q;
    assign o_last    = s2_last_q;
    assign o_pkt_cnt = cnt_q;
endmodule

// File: tb/tb_deparser_merge_shift.sv
// tb_deparser_merge_shift: directed + random stimulus against a field-array reference model
module tb_deparser_merge_shift;
    import deparser_pkg::*;
    localparam int FW = 16;
    localparam int HN = 16;
    localparam int MN = META_CANDI_NUM;
    localparam int DW = HN*FW;
    localparam int MW = MN*FW;
    localparam int CW = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [MW-1:0] m;
        logic          l;
    } beat_t;

    logic clk = 1'b0, rst = 1'b1, i_valid = 1'b0, i_last = 1'b0, i_ready = 1'b1;
    logic [DW-1:0] i_data = '0;
    logic [MW-1:0] i_meta = '0;
    logic [KEY_OFFSET_WIDTH:0] res [KEY_FILED_NUM];
    logic [REP_OFFSET_WIDTH:0] rep [META_CANDI_NUM];
    logic [HEAD_SHIFT_WIDTH-1:0] hs = '0;
    logic [META_SHIFT_WIDTH-1:0] ms = '0;
    logic o_ready, o_valid, o_last;
    logic [DW-1:0] o_data;
    logic [MW-1:0] o_meta;
    logic [CW-1:0] o_pkt_cnt;

    int n_assert = 0, n_fail = 0;
    logic in_body = 1'b0;
    logic [CW-1:0] exp_cnt = '0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    deparser_merge_shift #(.FIELD_WIDTH(FW), .HEAD_FIELD_NUM(HN), .CNT_WIDTH(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_data(i_data), .i_meta(i_meta),
        .i_last(i_last), .o_ready(o_ready), .i_result(res), .i_replaceOffset(rep),
        .i_headShift(hs), .i_metaShift(ms), .o_valid(o_valid), .o_data(o_data),
        .o_meta(o_meta), .o_last(o_last), .i_ready(i_ready), .o_pkt_cnt(o_pkt_cnt)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic beat_t model_beat();
        beat_t b;
        logic [FW-1:0] f [HN];
        logic [FW-1:0] mf [MN];
        int k, idx;
        b.l = i_last;
        b.d = '0;
        b.m = '0;
        if (in_body) begin
            b.d = i_data;
            return b;
        end
        for (int i = 0; i < HN; i++) f[i] = i_data[i*FW +: FW];
        for (int j = 0; j < MN; j++) mf[j] = i_meta[j*FW +: FW];
        for (int j = 0; j < MN; j++) begin
            if (rep[j][REP_OFFSET_WIDTH]) begin
                k = int'(rep[j][REP_OFFSET_WIDTH-1:0]);
                if (res[k][KEY_OFFSET_WIDTH]) begin
                    idx = int'(res[k][KEY_OFFSET_WIDTH-1:0]);
                    if (idx < HN) f[idx] = mf[j];
                end
            end
        end
        for (int i = 0; i < HN; i++) if (i + int'(hs) < HN) b.d[i*FW +: FW] = f[i + int'(hs)];
        for (int i = 0; i < MN; i++) if (i + int'(ms) < MN) b.m[i*FW +: FW] = mf[i + int'(ms)];
        return b;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            in_body = 1'b0;
            exp_cnt = '0;
        end else begin
            chk("o_ready", DW'(o_ready), DW'(!o_valid || i_ready));
            chk("o_pkt_cnt", DW'(o_pkt_cnt), DW'(exp_cnt));
            if (o_valid && i_ready) begin
                n_assert++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL spurious_beat: observed queue size %0d expected >0", exp_q.size());
                end
                if (exp_q.size() > 0) begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("beat_data", o_data, b.d);
                    chk("beat_meta", DW'(o_meta), DW'(b.m));
                    chk("beat_last", DW'(o_last), DW'(b.l));
                    if (o_last) exp_cnt = exp_cnt + 1'b1;
                end
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(model_beat());
                in_body = !i_last;
            end
        end
    end

    task automatic beat(input logic last);
        int n = 0;
        i_valid = 1'b1;
        i_last = last;
        @(negedge clk);
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", DW'(o_ready), DW'(1));
        @(posedge clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        @(negedge clk);
        while (!o_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("out_timeout", DW'(o_valid), DW'(1));
    endtask

    task automatic base_fields();
        for (int f = 0; f < HN; f++) i_data[f*FW +: FW] = FW'(32'h1000 + f);
        for (int j = 0; j < MN; j++) i_meta[j*FW +: FW] = FW'(32'hA000 + j);
        foreach (res[i]) res[i] = '0;
        foreach (rep[i]) rep[i] = '0;
        res[2] = {1'b1, 5'd5};
        rep[0] = {1'b1, 3'd2};
    endtask

    initial begin
        logic [DW-1:0] exp_d;
        logic [CW-1:0] pre;
        int guard;
        foreach (res[i]) res[i] = '0;
        foreach (rep[i]) rep[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", DW'(o_valid), DW'(0));
        chk("rst_data", o_data, DW'(0));
        chk("rst_meta", DW'(o_meta), DW'(0));
        chk("rst_last", DW'(o_last), DW'(0));
        chk("rst_cnt", DW'(o_pkt_cnt), DW'(0));
        @(posedge clk);
        #1;

        base_fields();
        beat(1'b1);
        @(negedge clk);
        chk("lat_1cyc_valid", DW'(o_valid), DW'(0));
        @(negedge clk);
        chk("lat_2cyc_valid", DW'(o_valid), DW'(1));
        chk("replace_f5", DW'(o_data[5*FW +: FW]), DW'(16'hA000));
        exp_d = i_data;
        exp_d[5*FW +: FW] = 16'hA000;
        chk("replace_all", o_data, exp_d);
        chk("replace_last", DW'(o_last), DW'(1));
        @(negedge clk);
        chk("replace_cnt", DW'(o_pkt_cnt), DW'(1));
        @(posedge clk);
        #1;

        hs = 5'd3;
        ms = 4'd1;
        beat(1'b1);
        wait_out();
        chk("shift_f0", DW'(o_data[0 +: FW]), DW'(16'h1003));
        chk("shift_f2", DW'(o_data[2*FW +: FW]), DW'(16'hA000));
        chk("shift_top3", DW'(o_data[DW-1 -: 3*FW]), DW'(0));
        chk("shift_meta0", DW'(o_meta[0 +: FW]), DW'(16'hA001));
        @(posedge clk);
        #1;

        hs = '0;
        ms = '0;
        rep[1] = {1'b1, 3'd2};
        rep[3] = {1'b1, 3'd2};
        rep[4] = {1'b1, 3'd6};
        beat(1'b1);
        wait_out();
        exp_d = i_data;
        exp_d[5*FW +: FW] = 16'hA003;
        chk("collide_f5", DW'(o_data[5*FW +: FW]), DW'(16'hA003));
        chk("collide_f6", DW'(o_data[6*FW +: FW]), DW'(16'h1006));
        chk("collide_all", o_data, exp_d);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;

        pre = o_pkt_cnt;
        beat(1'b0);
        for (int f = 0; f < HN; f++) i_data[f*FW +: FW] = FW'($urandom);
        i_meta = {4{32'($urandom)}};
        beat(1'b0);
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_last = 1'b1;
        for (int f = 0; f < HN; f++) i_data[f*FW +: FW] = FW'($urandom);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("stall_ready", DW'(o_ready), DW'(0));
        end
        @(posedge clk);
        #1 i_ready = 1'b1;
        beat(1'b1);
        repeat (6) @(negedge clk);
        chk("stall_cnt_once", DW'(o_pkt_cnt), DW'(CW'(pre + 1'b1)));
        chk("stall_drained", DW'(exp_q.size()), DW'(0));
        @(posedge clk);
        #1;

        base_fields();
        for (int f = 0; f < HN; f++) i_data[f*FW +: FW] = FW'(32'h1000 + f);
        beat(1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", DW'(o_valid), DW'(0));
        chk("midrst_cnt", DW'(o_pkt_cnt), DW'(0));
        @(posedge clk);
        #1;
        beat(1'b1);
        wait_out();
        chk("midrst_cnt_before_last", DW'(o_pkt_cnt), DW'(0));
        chk("midrst_head_f5", DW'(o_data[5*FW +: FW]), DW'(16'hA000));
        @(negedge clk);
        chk("midrst_cnt_after", DW'(o_pkt_cnt), DW'(1));
        @(posedge clk);
        #1;

        guard = 0;
        while (o_pkt_cnt != 4'hF && guard < 20) begin
            beat(1'b1);
            repeat (4) @(negedge clk);
            @(posedge clk);
            #1;
            guard++;
        end
        chk("wrap_preload", DW'(o_pkt_cnt), DW'(4'hF));
        hs = 5'd16;
        beat(1'b1);
        wait_out();
        chk("oor_shift_zero", o_data, DW'(0));
        @(negedge clk);
        chk("wrap_cnt", DW'(o_pkt_cnt), DW'(0));

        @(posedge clk);
        #1;
        repeat (300) begin
            i_valid = 1'($urandom_range(0, 1));
            i_last = ($urandom_range(0, 2) == 0);
            i_ready = ($urandom_range(0, 3) != 0);
            for (int f = 0; f < HN; f++) i_data[f*FW +: FW] = FW'($urandom);
            for (int j = 0; j < MN; j++) i_meta[j*FW +: FW] = FW'($urandom);
            foreach (res[i]) res[i] = 6'($urandom);
            foreach (rep[i]) rep[i] = 4'($urandom);
            hs = 5'($urandom_range(0, 17));
            ms = 4'($urandom_range(0, 9));
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("random_drain", DW'(exp_q.size()), DW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/deparser_merge_shift.md
Name: deparser_merge_shift

Overview:
- Deparser stage directly downstream of the type-lookup block (instantiated with zero lookup delay), consuming its per-packet results: o_result, o_replaceOffset, o_headShift and o_metaShift.
- On the header beat of each packet it writes selected metadata candidates into header fields at the looked-up key offsets, then left-shifts the header and the metadata by the looked-up amounts.
- Body beats pass through unchanged.
- Output feeds the deparser packet assembler through a valid/ready stream.

Parameters:
- FIELD_WIDTH, 16: bits per header/metadata field.
- HEAD_FIELD_NUM, 16: fields per beat; DATA_WIDTH = HEAD_FIELD_NUM*FIELD_WIDTH.
- CNT_WIDTH, 32: width of the packet counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset: synchronous, active-high.
- i_valid  in  1  input beat valid.
- i_data  in  DATA_WIDTH  beat; field f = bits [f*FIELD_WIDTH +: FIELD_WIDTH]; the first beat of a packet is the header.
- i_meta  in  `META_CANDI_NUM*FIELD_WIDTH  metadata candidates; sampled on the header beat only.
- i_last  in  1  last beat of packet.
- o_ready  out  1  input accepted when i_valid&&o_ready.
- i_result  in  [`KEY_FILED_NUM][`KEY_OFFSET_WIDTH+1]  per key k: {valid, header field index}.
- i_replaceOffset  in  [`META_CANDI_NUM][`REP_OFFSET_WIDTH+1]  per candidate j: {valid, key index k}.
- i_headShift  in  `HEAD_SHIFT_WIDTH  header shift, in fields.
- i_metaShift  in  `META_SHIFT_WIDTH  metadata shift, in fields.
- o_valid  out  1  output beat valid.
- o_data  out  DATA_WIDTH  processed beat.
- o_meta  out  `META_CANDI_NUM*FIELD_WIDTH  shifted metadata; meaningful on the header beat, 0 on body beats.
- o_last  out  1  last beat.
- i_ready  in  1  downstream ready.
- o_pkt_cnt  out  CNT_WIDTH  count of packets whose last beat was output.

Behaviour:
- Reset (i_rst high at a clock edge): FSM goes to S_HEAD; both pipeline valids are cleared; o_valid, o_data, o_meta, o_last and o_pkt_cnt are all 0. A packet in flight is discarded and the next accepted beat is treated as a header.
- Pipeline structure: two register stages, S1 and S2.
  - adv = !o_valid || i_ready; o_ready = adv.
  - When adv=1, S2<=S1 and S1<=input.
  - When adv=0, all registers hold.
  - Latency: 2 cycles from input acceptance to o_valid with no stall; throughput 1 beat/cycle.
- FSM, advanced only on accepted beats:
  - S_HEAD: an accepted beat is processed as a header and tagged is_head. If i_last=0 go to S_BODY; if i_last=1 stay in S_HEAD (single-beat packet).
  - S_BODY: accepted beats pass through untouched, with o_meta=0. An accepted beat with i_last=1 returns the FSM to S_HEAD.
- Lookup inputs are sampled only with the header beat and are ignored otherwise.
- S1 replace, header beats only. For each j = 0..`META_CANDI_NUM-1 in ascending order:
  - k = i_replaceOffset[j][low bits].
  - If i_replaceOffset[j] is valid AND i_result[k] is valid AND its field index < HEAD_FIELD_NUM, then data field i_result[k][low bits] is replaced by meta field j.
  - If several candidates target the same field, the highest j wins.
  - A valid replace entry that points at an invalid key is a no-op.
- S2 shift, header beats only:
  - o_data field i = in field i+headShift when i+headShift < HEAD_FIELD_NUM, else 0.
  - o_meta uses the same rule with metaShift over `META_CANDI_NUM fields.
  - headShift=0 gives identity; headShift >= HEAD_FIELD_NUM gives all zeros.
- o_pkt_cnt increments by 1 on each output handshake (o_valid && i_ready) where o_last=1, and wraps from all-ones to 0.
- Data, meta and last registers are loaded only when adv=1; their values while valid=0 are don't-care, except immediately after reset, when they are 0.

Decomposition:
- Shared package deparser_pkg holds:
  - FIELD_WIDTH and HEAD_FIELD_NUM defaults;
  - the `KEY_FILED_NUM, `META_CANDI_NUM, `*_OFFSET_WIDTH and `*_SHIFT_WIDTH constants;
  - typedefs key_off_t, rep_off_t, field_t, and the state enum {S_HEAD, S_BODY}.
- One sub-module: field_shifter (parameterised field count and width; combinational left-shift with zero-fill).
  - Instantiated twice in S2, once for the header and once for the metadata.

Test Plan:
- Replace: a 1-beat packet with data field f = 0x1000+f, meta j = 0xA000+j, result[2] = {1,5}, replaceOffset[0] = {1,2}, all other entries invalid, shifts 0 -> o_data field 5 = 0xA000, all other fields unchanged, o_last=1, o_valid 2 cycles after acceptance, o_pkt_cnt=1.
- Shift: same packet with headShift=3 and metaShift=1 -> o_data field 0 = 0x1003, fields 13..15 = 0; o_meta field 0 = 0xA001.
- Collision and invalid key: replaceOffset[1] = {1,2} and [3] = {1,2}; replaceOffset[4] = {1,6} with result[6] invalid -> field 5 = 0xA003, nothing else replaced.
- Multi-beat packet with backpressure: a 3-beat packet with i_ready low for 4 cycles mid-stream -> beats emerge in order, body beats are bit-exact with o_meta=0, no beat is lost or duplicated, o_ready=0 throughout the stall, o_pkt_cnt increments once.
- Reset mid-packet: assert i_rst after the header beat of a 3-beat packet -> o_valid=0 next cycle. A following packet's first beat is treated as a header (its replace is applied), and o_pkt_cnt=0 before that packet's last beat is output.
- Wrap and out-of-range shift: preload o_pkt_cnt to 0xFFFF_FFFF by running packets (or with CNT_WIDTH=4 for 15 packets) -> the next packet gives 0; headShift=16 -> o_data all zeros.
